pll_acc_integrator: RTL and testbench
=====================================

# pll_acc_integrator

Parametrised accumulator for the PLL linear model's loop filter and phase integrator. It generalises the fixed 24-bit integrators in three ways: a wider internal accumulator with a programmable input gain shift, selectable saturate or wrap overflow handling, and a sticky overflow flag. It also replaces delay-based output timing with a parametrised register pipeline, a valid handshake, a preload port and a synchronous reset. One or more instances sit between the phase detector and the DCO model. Each instance integrates the phase error (integral path), or the integrated frequency into phase.

## Interface
- W, 24: input/output sample width, signed two's complement.
- ACC_W, 32: accumulator width. Must be at least W.
- DELAY, 0: extra output register stages, 0..8.
- SAT, 1: 1 = saturate on overflow, 0 = wrap modulo 2^ACC_W.

- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous reset, active-high.
- in_valid  in  1  in_data is accumulated on this edge.
- in_data  in  W  signed increment.
- ki_shift  in  5  left-shift applied to in_data before accumulation. Values above ACC_W-W are treated as ACC_W-W.
- load_en  in  1  preload accumulator.
- load_val  in  W  signed preload value.
- out_valid  out  1  one-cycle pulse per accepted update.
- out_data  out  W  signed, equal to acc[ACC_W-1 : ACC_W-W].
- ovf  out  1  sticky overflow flag.

## Operation
- Increment term: sign-extend in_data to ACC_W+1 bits, then arithmetic left shift by min(ki_shift, ACC_W-W). Setting ki_shift = ACC_W-W gives unity gain W-to-W.
- Sum: computed in ACC_W+1 bits as acc + term. Overflow occurs when the sum falls outside the signed ACC_W range.
- Overflow handling:
  - SAT=1: clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1).
  - SAT=0: keep the low ACC_W bits.
  - In both modes, ovf is set and stays set.
- Load: when load_en=1, acc <= sign-extended load_val << (ACC_W-W) and ovf <= 0.
  - in_valid in the same cycle is ignored and its sample is discarded.
  - A load counts as an update and produces an out_valid pulse.
- Idle: with in_valid=0 and load_en=0, acc, ovf and out_data hold.
- Output pipeline: stage 0 is the acc register. DELAY further registers carry {valid, data}. Each register stage captures its input every cycle, with no stall.
- out_data: holds the last pipelined value between pulses. It never returns to 0 except on reset.
- ki_shift: sampled on the accepting edge only. It may change every cycle.

## Timing
- RST=1 at an edge clears acc, all pipeline stages, out_valid, out_data and ovf to 0. RST has priority over load_en and in_valid.
- Latency: an update accepted at edge t appears on out_data/out_valid after edge t+DELAY.
  - DELAY=0: visible immediately after edge t.
- Throughput: one update per cycle. Back-to-back in_valid gives consecutive out_valid pulses with running sums.
- Reset mid-operation: in-flight pipeline entries are flushed. No out_valid pulse appears for samples accepted before the reset edge.
- ovf: rises after the edge that produced the overflow, at stage 0 and not delayed by DELAY. It clears only on RST or load_en.
- Zero increment: in_valid with in_data=0 still produces an out_valid pulse with the unchanged value.

## Test plan
- Unity gain: W=24, ACC_W=32, DELAY=0, ki_shift=8; reset, then in_data=100 valid for 3 cycles -> out_data 100, 200, 300 with out_valid high on each of the 3 cycles, ovf=0.
- Fractional gain: ki_shift=0, in_data=1 valid for 256 cycles -> out_data stays 0 for samples 1..255 and becomes 1 on sample 256; then in_data=-256 once -> out_data 0.
- Positive overflow:
  - SAT=1: load 0x7FFFF0, then in_data=0x20 at unity gain -> out_data 0x7FFFFF, ovf=1.
  - SAT=0, same stimulus -> out_data 0x800010, ovf=1.
  - Then load 0 -> ovf=0.
- Negative overflow, SAT=1: load 0x800000, in_data=-1 -> out_data 0x800000 (held at min), ovf=1. A further in_data=+1 -> 0x800001.
- Load/accumulate collision: acc=500, load_en=1 with load_val=-7 and in_valid=1 with in_data=1000 on the same edge -> out_data -7, exactly one out_valid pulse.
- Pipeline and reset: DELAY=3, in_data=5 valid at edge t -> out_valid only after edge t+3, out_data 5. Repeat with RST=1 at edge t+1 -> no out_valid pulse ever appears, out_data=0.

Source files
------------

// File: rtl/pll_acc_integrator.sv
// Parametrised PLL loop-filter / phase integrator: gain-shifted accumulate with
// saturate-or-wrap overflow, sticky overflow flag, preload and a delay pipeline.
module pll_acc_integrator #(
    parameter int W     = 24,
    parameter int ACC_W = 32,
    parameter int DELAY = 0,
    parameter int SAT   = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic [4:0]   ki_shift,
    input  logic         load_en,
    input  logic [W-1:0] load_val,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         ovf
);

    localparam int MAX_SH = ACC_W - W;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    function automatic logic [ACC_W:0] sext_wide(input logic [W-1:0] v);
        logic [ACC_W:0] r;
        r        = {(ACC_W+1){v[W-1]}};
        r[W-1:0] = v;
        return r;
    endfunction

    function automatic logic [ACC_W-1:0] sext_acc(input logic [W-1:0] v);
        logic [ACC_W-1:0] r;
        r        = {ACC_W{v[W-1]}};
        r[W-1:0] = v;
        return r;
    endfunction

    logic [ACC_W-1:0] acc_r;
    logic             valid0_r;
    logic             ovf_r;

    int               shift_s;
    logic [ACC_W:0]   term_s;
    logic [ACC_W:0]   sum_s;
    logic             ovf_now_s;
    logic [ACC_W-1:0] acc_next_s;
    logic [ACC_W-1:0] load_ext_s;

    // Gain-shifted increment, widened sum and overflow resolution.
    always_comb begin
        shift_s    = 0;
        term_s     = '0;
        sum_s      = '0;
        ovf_now_s  = 1'b0;
        acc_next_s = '0;
        load_ext_s = '0;
        if (int'(ki_shift) > MAX_SH) begin
            shift_s = MAX_SH;
        end else begin
            shift_s = int'(ki_shift);
        end
        term_s     = sext_wide(in_data) << shift_s;
        sum_s      = {acc_r[ACC_W-1], acc_r} + term_s;
        ovf_now_s  = sum_s[ACC_W] ^ sum_s[ACC_W-1];
        if (ovf_now_s && (SAT != 0)) begin
            acc_next_s = sum_s[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_next_s = sum_s[ACC_W-1:0];
        end
        load_ext_s = sext_acc(load_val) << MAX_SH;
    end

    // Stage 0: accumulator, update strobe and sticky overflow; load beats accumulate.
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_r    <= '0;
            valid0_r <= 1'b0;
            ovf_r    <= 1'b0;
        end else if (load_en) begin
            acc_r    <= load_ext_s;
            valid0_r <= 1'b1;
            ovf_r    <= 1'b0;
        end else if (in_valid) begin
            acc_r    <= acc_next_s;
            valid0_r <= 1'b1;
            ovf_r    <= ovf_r | ovf_now_s;
        end else begin
            acc_r    <= acc_r;
            valid0_r <= 1'b0;
            ovf_r    <= ovf_r;
        end
    end

    assign ovf = ovf_r;

    generate
        if (DELAY == 0) begin : g_nodelay
            assign out_valid = valid0_r;
            assign out_data  = acc_r[ACC_W-1 -: W];
        end else begin : g_delay
            logic [DELAY-1:0] pv_r;
            logic [W-1:0]     pd_r [DELAY];

            // Free-running delay line carrying {valid, data}; reset flushes in-flight entries.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    for (int i = 0; i < DELAY; i++) begin
                        pv_r[i] <= 1'b0;
                        pd_r[i] <= '0;
                    end
                end else begin
                    pv_r[0] <= valid0_r;
                    pd_r[0] <= acc_r[ACC_W-1 -: W];
                    for (int i = 1; i < DELAY; i++) begin
                        pv_r[i] <= pv_r[i-1];
                        pd_r[i] <= pd_r[i-1];
                    end
                end
            end

            assign out_valid = pv_r[DELAY-1];
            assign out_data  = pd_r[DELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_pll_acc_integrator.sv
// Directed bench for pll_acc_integrator: saturating, wrapping and delayed
// instances share one stimulus stream; expected values are hand-computed.
module tb_pll_acc_integrator;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic [23:0] in_data;
    logic [4:0]  ki_shift;
    logic        load_en;
    logic [23:0] load_val;

    logic        s_valid, w_valid, d_valid;
    logic [23:0] s_data, w_data, d_data;
    logic        s_ovf, w_ovf, d_ovf;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    pll_acc_integrator #(.W(24), .ACC_W(32), .DELAY(0), .SAT(1)) dut_sat (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data),
        .ki_shift(ki_shift), .load_en(load_en), .load_val(load_val),
        .out_valid(s_valid), .out_data(s_data), .ovf(s_ovf));

    pll_acc_integrator #(.W(24), .ACC_W(32), .DELAY(0), .SAT(0)) dut_wrap (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data),
        .ki_shift(ki_shift), .load_en(load_en), .load_val(load_val),
        .out_valid(w_valid), .out_data(w_data), .ovf(w_ovf));

    pll_acc_integrator #(.W(24), .ACC_W(32), .DELAY(3), .SAT(1)) dut_dly (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data),
        .ki_shift(ki_shift), .load_en(load_en), .load_val(load_val),
        .out_valid(d_valid), .out_data(d_data), .ovf(d_ovf));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        load_en  = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        idle();
        step();
        RST = 1'b0;
    endtask

    initial begin
        RST      = 1'b1;
        in_valid = 1'b0;
        in_data  = 24'd0;
        ki_shift = 5'd8;
        load_en  = 1'b0;
        load_val = 24'd0;
        #2;
        do_reset();
        check("rst_data", {8'd0, s_data}, 32'd0);
        check("rst_valid", {31'd0, s_valid}, 32'd0);
        check("rst_ovf", {31'd0, s_ovf}, 32'd0);
        check("rst_dly_valid", {31'd0, d_valid}, 32'd0);

        // Unity gain running sum
        in_valid = 1'b1; in_data = 24'd100; ki_shift = 5'd8;
        step();
        check("unity1", {8'd0, s_data}, 32'd100);
        check("unity1_v", {31'd0, s_valid}, 32'd1);
        step();
        check("unity2", {8'd0, s_data}, 32'd200);
        check("unity2_v", {31'd0, s_valid}, 32'd1);
        step();
        check("unity3", {8'd0, s_data}, 32'd300);
        check("unity3_v", {31'd0, s_valid}, 32'd1);
        check("unity_ovf", {31'd0, s_ovf}, 32'd0);
        idle();
        step();
        check("hold_v", {31'd0, s_valid}, 32'd0);
        check("hold_data", {8'd0, s_data}, 32'd300);

        // Fractional gain: 256 unit samples make one output LSB
        do_reset();
        in_valid = 1'b1; in_data = 24'd1; ki_shift = 5'd0;
        for (int i = 1; i <= 256; i++) begin
            step();
            if (i == 255) check("frac255", {8'd0, s_data}, 32'd0);
            if (i == 256) check("frac256", {8'd0, s_data}, 32'd1);
        end
        in_data = 24'hFFFF00;
        step();
        check("frac_neg", {8'd0, s_data}, 32'd0);

        // ki_shift above ACC_W-W clamps to unity gain
        in_data = 24'd3; ki_shift = 5'd31;
        step();
        check("shift_clamp", {8'd0, s_data}, 32'd3);

        // Positive overflow
        idle();
        load_en = 1'b1; load_val = 24'h7FFFF0;
        step();
        check("load_pos", {8'd0, s_data}, 32'h7FFFF0);
        check("load_pos_v", {31'd0, s_valid}, 32'd1);
        load_en = 1'b0; in_valid = 1'b1; in_data = 24'h000020; ki_shift = 5'd8;
        step();
        check("sat_pos", {8'd0, s_data}, 32'h7FFFFF);
        check("sat_pos_ovf", {31'd0, s_ovf}, 32'd1);
        check("wrap_pos", {8'd0, w_data}, 32'h800010);
        check("wrap_pos_ovf", {31'd0, w_ovf}, 32'd1);
        idle();
        step();
        check("ovf_sticky", {31'd0, s_ovf}, 32'd1);
        load_en = 1'b1; load_val = 24'd0;
        step();
        check("ovf_clr", {31'd0, s_ovf}, 32'd0);
        check("ovf_clr_w", {31'd0, w_ovf}, 32'd0);
        check("load0", {8'd0, s_data}, 32'd0);

        // Negative overflow
        load_val = 24'h800000;
        step();
        load_en = 1'b0; in_valid = 1'b1; in_data = 24'hFFFFFF;
        step();
        check("sat_neg", {8'd0, s_data}, 32'h800000);
        check("sat_neg_ovf", {31'd0, s_ovf}, 32'd1);
        check("wrap_neg", {8'd0, w_data}, 32'h7FFFFF);
        in_data = 24'd1;
        step();
        check("sat_neg_up", {8'd0, s_data}, 32'h800001);
        check("wrap_neg_up", {8'd0, w_data}, 32'h800000);

        // Load/accumulate collision
        idle();
        load_en = 1'b1; load_val = 24'd500;
        step();
        check("pre_collide", {8'd0, s_data}, 32'd500);
        load_val = 24'hFFFFF9; in_valid = 1'b1; in_data = 24'd1000;
        step();
        check("collide", {8'd0, s_data}, 32'h00FFFFF9);
        check("collide_v", {31'd0, s_valid}, 32'd1);
        idle();
        step();
        check("collide_one", {31'd0, s_valid}, 32'd0);

        // Zero increment still pulses
        in_valid = 1'b1; in_data = 24'd0;
        step();
        check("zero_inc", {8'd0, s_data}, 32'h00FFFFF9);
        check("zero_inc_v", {31'd0, s_valid}, 32'd1);

        // Pipeline latency with DELAY=3
        do_reset();
        in_valid = 1'b1; in_data = 24'd5; ki_shift = 5'd8;
        step();
        idle();
        check("dly_t0", {31'd0, d_valid}, 32'd0);
        step();
        check("dly_t1", {31'd0, d_valid}, 32'd0);
        step();
        check("dly_t2", {31'd0, d_valid}, 32'd0);
        step();
        check("dly_t3", {31'd0, d_valid}, 32'd1);
        check("dly_t3_data", {8'd0, d_data}, 32'd5);
        step();
        check("dly_t4", {31'd0, d_valid}, 32'd0);
        check("dly_t4_data", {8'd0, d_data}, 32'd5);

        // Reset mid-flight flushes the pipeline
        do_reset();
        in_valid = 1'b1; in_data = 24'd5;
        step();
        idle();
        RST = 1'b1;
        step();
        RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("flush_v", {31'd0, d_valid}, 32'd0);
            check("flush_data", {8'd0, d_data}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
